// File: rtl/axis_read_interface.sv
// rtl/axis_read_interface.sv - BRAM to AXI-Stream packet transmitter with 2-entry skid buffer
module axis_read_interface #(
  parameter int data_width     = 512,
  parameter int counter_width  = 10,
  parameter int mem_size_depth = 1024,
  parameter int keep_width     = data_width / 8
) (
  input  logic                     axis_clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [counter_width-1:0] start_addr,
  input  logic [counter_width:0]   pkt_len,
  input  logic [keep_width-1:0]    last_keep,
  input  logic [data_width-1:0]    bram_dout,
  output logic                     bram_ena,
  output logic                     bram_wena,
  output logic [counter_width-1:0] bram_address,
  output logic [data_width-1:0]    bram_data,
  output logic                     t_valid,
  output logic [data_width-1:0]    t_data,
  output logic                     t_last,
  output logic [keep_width-1:0]    t_keep,
  input  logic                     t_ready,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [counter_width-1:0] last_addr = counter_width'(mem_size_depth - 1);

  state_t                 state;
  logic [counter_width:0] len_r;
  logic [counter_width:0] rd_cnt;
  logic [counter_width:0] sent_cnt;
  logic [keep_width-1:0]  keep_r;
  logic [data_width-1:0]  fifo_mem [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             occ;
  logic                   pend;
  logic                   pop;
  logic                   last_issue;
  logic [2:0]             level;

  assign t_valid   = (occ != 2'd0);
  assign pop       = t_valid & t_ready;
  assign t_last    = t_valid && (sent_cnt == len_r - 1'b1);
  assign t_keep    = !t_valid ? '0 : (t_last ? keep_r : '1);
  assign t_data    = t_valid ? fifo_mem[rd_ptr] : '0;
  assign busy      = (state != IDLE);
  assign bram_wena = 1'b0;
  assign bram_data = '0;

  // Buffered beats plus the read whose data lands next edge, less the beat leaving now;
  // keeping this below 2 means the buffer can never be pushed while full.
  assign level      = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};
  assign bram_ena   = (state == READ) && (level < 3'd2);
  assign last_issue = bram_ena && (rd_cnt == len_r - 1'b1);

  always_ff @(posedge axis_clk) begin
    if (pend) fifo_mem[wr_ptr] <= bram_dout;
  end

  always_ff @(posedge axis_clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      len_r        <= '0;
      rd_cnt       <= '0;
      sent_cnt     <= '0;
      keep_r       <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      occ          <= 2'd0;
      pend         <= 1'b0;
      bram_address <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      pend <= bram_ena;
      occ  <= occ + {1'b0, pend} - {1'b0, pop};
      if (pend) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        sent_cnt <= sent_cnt + 1'b1;
      end
      if (bram_ena) begin
        bram_address <= (bram_address == last_addr) ? '0 : bram_address + 1'b1;
        rd_cnt       <= rd_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start && (pkt_len != '0)) begin
            state        <= READ;
            len_r        <= pkt_len;
            keep_r       <= last_keep;
            bram_address <= start_addr;
            rd_cnt       <= '0;
            sent_cnt     <= '0;
          end
        end
        READ: begin
          if (last_issue) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && t_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_read_interface.sv
// tb/tb_axis_read_interface.sv - directed bench for axis_read_interface
module tb_axis_read_interface;

  logic         axis_clk = 1'b0;
  logic         reset;
  logic         start;
  logic [9:0]   start_addr;
  logic [10:0]  pkt_len;
  logic [63:0]  last_keep;
  logic [511:0] bram_dout;
  logic         bram_ena;
  logic         bram_wena;
  logic [9:0]   bram_address;
  logic [511:0] bram_data;
  logic         t_valid;
  logic [511:0] t_data;
  logic         t_last;
  logic [63:0]  t_keep;
  logic         t_ready;
  logic         busy;
  logic         done;

  int vectors = 0;
  int miscompares = 0;

  logic [511:0] mem [1024];

  axis_read_interface dut (
    .axis_clk(axis_clk), .reset(reset), .start(start), .start_addr(start_addr),
    .pkt_len(pkt_len), .last_keep(last_keep), .bram_dout(bram_dout),
    .bram_ena(bram_ena), .bram_wena(bram_wena), .bram_address(bram_address),
    .bram_data(bram_data), .t_valid(t_valid), .t_data(t_data), .t_last(t_last),
    .t_keep(t_keep), .t_ready(t_ready), .busy(busy), .done(done)
  );

  always #5 axis_clk = ~axis_clk;

  always @(posedge axis_clk) if (bram_ena) bram_dout <= mem[bram_address];

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctrl"}, 640'({t_valid, t_last, busy, done, bram_ena, bram_wena}), 640'(0));
    chk({tag, "_addr"}, 640'(bram_address), 640'(0));
    chk({tag, "_data"}, 640'(t_data), 640'(0));
    chk({tag, "_keep"}, 640'(t_keep), 640'(0));
    chk({tag, "_wdata"}, 640'(bram_data), 640'(0));
  endtask

  // mode 0: t_ready held high; mode 1: t_ready high one cycle in three
  task automatic send(input logic [9:0] addr, input logic [10:0] len, input logic [63:0] keep,
                      input int mode, input int restart_at);
    int beats = 0, issued = 0, first_valid = -1, done_cnt = 0, done_cyc = -1, last_hs = -1;
    int viol = 0, stab = 0, aerr = 0, a, ncyc;
    logic held_v = 1'b0;
    logic [576:0] held = '0, cur, expb;
    logic bl;
    ncyc = 3 * int'(len) + 12;
    @(negedge axis_clk);
    start = 1'b1; start_addr = addr; pkt_len = len; last_keep = keep; t_ready = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge axis_clk);
      start = (k == restart_at);
      if (k == restart_at) begin start_addr = 10'd100; pkt_len = 11'd5; end
      t_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      #1;
      if (k == 1) begin
        chk("start_ena", 640'(bram_ena), 640'(1));
        chk("start_addr", 640'(bram_address), 640'(addr));
      end
      cur = {t_last, t_keep, t_data};
      if (held_v && (!t_valid || cur !== held)) stab++;
      if (t_valid && first_valid < 0) first_valid = k;
      if (done) begin done_cnt++; done_cyc = k; end
      if (bram_ena) begin
        if (issued - beats - int'(t_valid && t_ready) >= 2) viol++;
        if (bram_address !== 10'(int'(addr) + issued)) aerr++;
        issued++;
      end
      if (t_valid && t_ready) begin
        a = (int'(addr) + beats) % 1024;
        bl = (beats == int'(len) - 1);
        expb = {bl, bl ? keep : 64'hFFFF_FFFF_FFFF_FFFF, 512'(a + 1)};
        chk("beat", 640'(cur), 640'(expb));
        beats++;
        last_hs = k;
      end
      held_v = t_valid && !t_ready;
      held = cur;
    end
    start = 1'b0; t_ready = 1'b0;
    chk("first_valid", 640'(first_valid), 640'(3));
    chk("beat_count", 640'(beats), 640'(len));
    chk("read_count", 640'(issued), 640'(len));
    chk("done_count", 640'(done_cnt), 640'(1));
    chk("done_cycle", 640'(done_cyc), 640'(last_hs + 1));
    chk("ena_cap", 640'(viol), 640'(0));
    chk("stable", 640'(stab), 640'(0));
    chk("addr_seq", 640'(aerr), 640'(0));
    chk("busy_end", 640'(busy), 640'(0));
  endtask

  initial begin
    int err;
    for (int i = 0; i < 1024; i++) mem[i] = 512'(i + 1);
    reset = 1'b1; start = 1'b0; start_addr = '0; pkt_len = '0; last_keep = '0; t_ready = 1'b0;
    repeat (3) @(negedge axis_clk);
    chk_idle_outputs("reset");
    reset = 1'b0;
    @(negedge axis_clk);
    #1 chk_idle_outputs("idle");

    send(10'd0, 11'd10, 64'h00FF, 0, 0);
    send(10'd0, 11'd10, 64'h00FF, 1, 0);
    send(10'd1022, 11'd4, 64'h000F, 0, 0);
    send(10'd7, 11'd1, 64'h0003, 0, 2);

    @(negedge axis_clk);
    start = 1'b1; start_addr = 10'd3; pkt_len = 11'd0; t_ready = 1'b1;
    err = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge axis_clk);
      start = 1'b0;
      #1 if (busy || t_valid || bram_ena || done) err++;
    end
    chk("zero_len", 640'(err), 640'(0));

    @(negedge axis_clk);
    start = 1'b1; start_addr = 10'd0; pkt_len = 11'd10; last_keep = 64'h00FF; t_ready = 1'b1;
    @(negedge axis_clk);
    start = 1'b0;
    repeat (5) @(negedge axis_clk);
    #1 chk("mid_valid", 640'({t_valid, busy}), 640'(2'b11));
    #2 reset = 1'b1;
    #1 chk_idle_outputs("mid_reset");
    @(negedge axis_clk);
    reset = 1'b0;
    err = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge axis_clk);
      #1 if (busy || t_valid || done || t_last) err++;
    end
    chk("post_reset_quiet", 640'(err), 640'(0));
    send(10'd5, 11'd3, 64'h0001, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
